id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/alu_ctrl_dec.sv | 31 +++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: ALU control codes, ALUOp classes and R-type funct values.
package pipe_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: ALUOp class plus R-type funct -> 3-bit ALU operation.
module alu_ctrl_dec
  import pipe_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output alu_ctrl_e  o_alu_ctrl
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    o_alu_ctrl = ALU_ADD;
    case (alu_op_e'(i_alu_op))
      ALUOP_ADD: o_alu_ctrl = ALU_ADD;
      ALUOP_SUB: o_alu_ctrl = ALU_SUB;
      ALUOP_OR:  o_alu_ctrl = ALU_OR;
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: o_alu_ctrl = ALU_ADD;
          FUNCT_SUB: o_alu_ctrl = ALU_SUB;
          FUNCT_AND: o_alu_ctrl = ALU_AND;
          FUNCT_OR:  o_alu_ctrl = ALU_OR;
          FUNCT_SLT: o_alu_ctrl = ALU_SLT;
          default:   o_alu_ctrl = ALU_ADD;
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode and EX/MEM, MEM/WB operand forwarding.
// Forwarding is built only when ID_EX_FORWARD_EN is defined; otherwise its ports are ignored.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic              EXMEM_RegWrite_i,
  input  logic [ADDR_W-1:0] EXMEM_RDaddr_i,
  input  logic [DATA_W-1:0] EXMEM_data_i,
  input  logic              MEMWB_RegWrite_i,
  input  logic [ADDR_W-1:0] MEMWB_RDaddr_i,
  input  logic [DATA_W-1:0] MEMWB_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        ALUCtrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [ADDR_W-1:0] RTaddr_o,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o
);

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [1:0]        r_alu_op;
  logic [5:0]        r_funct;
  logic              r_alu_src;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [ADDR_W-1:0] r_rs_addr;
  logic [ADDR_W-1:0] r_rt_addr;
  logic [ADDR_W-1:0] r_rd_addr;

  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;
  alu_ctrl_e         w_alu_ctrl;

  // Flush clears the data registers too; they are don't-care in a bubble and this keeps one clear path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments let every register sample pre-edge values, matching hardware.
    if (rst_i || flush_i) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_alu_op     <= '0;
      r_funct      <= '0;
      r_alu_src    <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_rd_addr    <= '0;
    end else if (!stall_i) begin
      r_valid      <= valid_i;
      r_reg_write  <= RegWrite_i;
      r_mem_to_reg <= MemtoReg_i;
      r_mem_read   <= MemRead_i;
      r_mem_write  <= MemWrite_i;
      r_alu_op     <= ALUOp_i;
      r_funct      <= funct_i;
      r_alu_src    <= ALUSrc_i;
      r_rs_data    <= RSdata_i;
      r_rt_data    <= RTdata_i;
      r_imm        <= imm_i;
      r_rs_addr    <= RSaddr_i;
      r_rt_addr    <= RTaddr_i;
      r_rd_addr    <= RDaddr_i;
    end
  end

  alu_ctrl_dec u_alu_ctrl_dec (
    .i_alu_op   (r_alu_op),
    .i_funct    (r_funct),
    .o_alu_ctrl (w_alu_ctrl)
  );

`ifdef ID_EX_FORWARD_EN
  // EX/MEM is checked first so the youngest producer wins; register 0 is never forwarded.
  always_comb begin
    w_rs_fwd = r_rs_data;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != '0) && (EXMEM_RDaddr_i == r_rs_addr))
      w_rs_fwd = EXMEM_data_i;
    else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == r_rs_addr))
      w_rs_fwd = MEMWB_data_i;
  end

  always_comb begin
    w_rt_fwd = r_rt_data;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != '0) && (EXMEM_RDaddr_i == r_rt_addr))
      w_rt_fwd = EXMEM_data_i;
    else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == r_rt_addr))
      w_rt_fwd = MEMWB_data_i;
  end
`else
  logic w_fwd_unused;
  assign w_fwd_unused = ^{EXMEM_RegWrite_i, EXMEM_RDaddr_i, EXMEM_data_i,
                          MEMWB_RegWrite_i, MEMWB_RDaddr_i, MEMWB_data_i, r_rs_addr};
  assign w_rs_fwd = r_rs_data;
  assign w_rt_fwd = r_rt_data;
`endif

  assign data1_o      = w_rs_fwd;
  assign data2_o      = r_alu_src ? r_imm : w_rt_fwd;
  assign store_data_o = w_rt_fwd;
  assign ALUCtrl_o    = w_alu_ctrl;
  assign RDaddr_o     = r_rd_addr;
  assign RTaddr_o     = r_rt_addr;
  assign valid_o      = r_valid;

  // An invalid slot must never write state, whatever its captured controls say.
  assign RegWrite_o   = r_valid & r_reg_write;
  assign MemRead_o    = r_valid & r_mem_read;
  assign MemWrite_o   = r_valid & r_mem_write;
  assign MemtoReg_o   = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, corner sequences, random vs. reference model.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [1:0]  ALUOp_i;
  logic [5:0]  funct_i;
  logic        ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] RSdata_i, RTdata_i, imm_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic        EXMEM_RegWrite_i, MEMWB_RegWrite_i;
  logic [4:0]  EXMEM_RDaddr_i, MEMWB_RDaddr_i;
  logic [31:0] EXMEM_data_i, MEMWB_data_i;
  logic [31:0] data1_o, data2_o, store_data_o;
  logic [2:0]  ALUCtrl_o;
  logic [4:0]  RDaddr_o, RTaddr_o;
  logic        valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .ALUSrc_i(ALUSrc_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
    .EXMEM_RegWrite_i(EXMEM_RegWrite_i), .EXMEM_RDaddr_i(EXMEM_RDaddr_i), .EXMEM_data_i(EXMEM_data_i),
    .MEMWB_RegWrite_i(MEMWB_RegWrite_i), .MEMWB_RDaddr_i(MEMWB_RDaddr_i), .MEMWB_data_i(MEMWB_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .ALUCtrl_o(ALUCtrl_o), .store_data_o(store_data_o),
    .RDaddr_o(RDaddr_o), .RTaddr_o(RTaddr_o), .valid_o(valid_o),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o)
  );

  // Reference model: the instruction currently held in the stage, as seen by ID.
  typedef struct {
    logic        valid, rw, m2r, mr, mw, alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
  } instr_t;

  instr_t held;

  function automatic instr_t zero_instr();
    instr_t z;
    z = '{valid: 1'b0, rw: 1'b0, m2r: 1'b0, mr: 1'b0, mw: 1'b0, alu_src: 1'b0,
          alu_op: 2'b0, funct: 6'b0, rs_data: 32'h0, rt_data: 32'h0, imm: 32'h0,
          rs_addr: 5'h0, rt_addr: 5'h0, rd_addr: 5'h0};
    return z;
  endfunction

  function automatic instr_t id_inputs();
    instr_t c;
    c = '{valid: valid_i, rw: RegWrite_i, m2r: MemtoReg_i, mr: MemRead_i, mw: MemWrite_i,
          alu_src: ALUSrc_i, alu_op: ALUOp_i, funct: funct_i, rs_data: RSdata_i,
          rt_data: RTdata_i, imm: imm_i, rs_addr: RSaddr_i, rt_addr: RTaddr_i, rd_addr: RDaddr_i};
    return c;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b11) return 3'b001;
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Value a reader of register `a` should see given the in-flight producers.
  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] regval);
    if (FWD && a != 0 && EXMEM_RegWrite_i && EXMEM_RDaddr_i == a) return EXMEM_data_i;
    if (FWD && a != 0 && MEMWB_RegWrite_i && MEMWB_RDaddr_i == a) return MEMWB_data_i;
    return regval;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] rt_op;
    rt_op = ref_operand(held.rt_addr, held.rt_data);
    check({tag, ".data1"},    data1_o, ref_operand(held.rs_addr, held.rs_data));
    check({tag, ".data2"},    data2_o, held.alu_src ? held.imm : rt_op);
    check({tag, ".store"},    store_data_o, rt_op);
    check({tag, ".aluctrl"},  32'(ALUCtrl_o), 32'(ref_alu(held.alu_op, held.funct)));
    check({tag, ".valid"},    32'(valid_o), 32'(held.valid));
    check({tag, ".regwrite"}, 32'(RegWrite_o), 32'(held.valid && held.rw));
    check({tag, ".memtoreg"}, 32'(MemtoReg_o), 32'(held.m2r));
    check({tag, ".memread"},  32'(MemRead_o), 32'(held.valid && held.mr));
    check({tag, ".memwrite"}, 32'(MemWrite_o), 32'(held.valid && held.mw));
    check({tag, ".rdaddr"},   32'(RDaddr_o), 32'(held.rd_addr));
    check({tag, ".rtaddr"},   32'(RTaddr_o), 32'(held.rt_addr));
  endtask

  // One clock edge; the model follows the stage rules, then outputs settle before checking.
  task automatic step();
    @(posedge clk_i);
    if (rst_i || flush_i) held = zero_instr();
    else if (!stall_i) held = id_inputs();
    #1;
  endtask

  task automatic no_fwd();
    EXMEM_RegWrite_i = 0; EXMEM_RDaddr_i = 0; EXMEM_data_i = 0;
    MEMWB_RegWrite_i = 0; MEMWB_RDaddr_i = 0; MEMWB_data_i = 0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs_addr, rt_addr;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] e_data1, e_data2, e_store;
    logic [2:0]  e_alu;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"cap_sub", 2'b10, 6'h22, 1'b0, 32'd9, 32'd4, 32'h0, 5'd1, 5'd2,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'd9, 32'd4, 32'd4, 3'b110};
    vecs[1]  = '{"prio_ex", 2'b00, 6'h00, 1'b0, 32'h1, 32'h2, 32'h0, 5'd3, 5'd4,
                 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555,
                 FWD ? 32'hAAAA : 32'h1, 32'h2, 32'h2, 3'b010};
    vecs[2]  = '{"prio_wb", 2'b00, 6'h00, 1'b0, 32'h1, 32'h2, 32'h0, 5'd3, 5'd4,
                 1'b0, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555,
                 FWD ? 32'h5555 : 32'h1, 32'h2, 32'h2, 3'b010};
    vecs[3]  = '{"zero_reg", 2'b01, 6'h00, 1'b0, 32'h0, 32'h3, 32'h0, 5'd0, 5'd7,
                 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd8, 32'h0, 32'h3, 32'h3, 3'b110};
    vecs[4]  = '{"imm_path", 2'b11, 6'h00, 1'b1, 32'h5, 32'h11, 32'hFFFF_FFFC, 5'd1, 5'd6,
                 1'b1, 5'd6, 32'h20, 1'b0, 5'd0, 32'h0,
                 32'h5, 32'hFFFF_FFFC, FWD ? 32'h20 : 32'h11, 3'b001};
    vecs[5]  = '{"f_and", 2'b10, 6'h24, 1'b0, 32'h6, 32'h9, 32'h0, 5'd1, 5'd5,
                 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h77,
                 32'h6, FWD ? 32'h77 : 32'h9, FWD ? 32'h77 : 32'h9, 3'b000};
    vecs[6]  = '{"f_or", 2'b10, 6'h25, 1'b0, 32'hF0, 32'h0F, 32'h0, 5'd8, 5'd9,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hF0, 32'h0F, 32'h0F, 3'b001};
    vecs[7]  = '{"f_slt", 2'b10, 6'h2A, 1'b0, 32'h1, 32'h2, 32'h0, 5'd10, 5'd10,
                 1'b1, 5'd10, 32'hBEEF, 1'b1, 5'd10, 32'hCAFE,
                 FWD ? 32'hBEEF : 32'h1, FWD ? 32'hBEEF : 32'h2, FWD ? 32'hBEEF : 32'h2, 3'b111};
    vecs[8]  = '{"f_add", 2'b10, 6'h20, 1'b0, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h3, 32'h4, 32'h4, 3'b010};
    vecs[9]  = '{"f_other", 2'b10, 6'h07, 1'b0, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h3, 32'h4, 32'h4, 3'b010};
    vecs[10] = '{"aluop_or", 2'b11, 6'h22, 1'b0, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h3, 32'h4, 32'h4, 3'b001};
  end

  initial begin
    rst_i = 1; stall_i = 0; flush_i = 0; valid_i = 0;
    ALUOp_i = 0; funct_i = 0; ALUSrc_i = 0;
    RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    RSdata_i = 0; RTdata_i = 0; imm_i = 0; RSaddr_i = 0; RTaddr_i = 0; RDaddr_i = 0;
    no_fwd();
    held = zero_instr();

    #2;
    check("rst.valid",   32'(valid_o), 32'h0);
    check("rst.aluctrl", 32'(ALUCtrl_o), 32'h2);
    check("rst.ctrl",    32'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}), 32'h0);
    check("rst.data1",   data1_o, 32'h0);
    step(); step();
    rst_i = 0;

    // Directed vectors: each captured instruction is checked one edge later.
    for (int i = 0; i < 11; i++) begin
      valid_i = 1; RegWrite_i = 1; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
      ALUOp_i = vecs[i].alu_op; funct_i = vecs[i].funct; ALUSrc_i = vecs[i].alu_src;
      RSdata_i = vecs[i].rs_data; RTdata_i = vecs[i].rt_data; imm_i = vecs[i].imm;
      RSaddr_i = vecs[i].rs_addr; RTaddr_i = vecs[i].rt_addr; RDaddr_i = 5'(i + 1);
      EXMEM_RegWrite_i = vecs[i].ex_we; EXMEM_RDaddr_i = vecs[i].ex_rd; EXMEM_data_i = vecs[i].ex_data;
      MEMWB_RegWrite_i = vecs[i].wb_we; MEMWB_RDaddr_i = vecs[i].wb_rd; MEMWB_data_i = vecs[i].wb_data;
      step();
      check({vecs[i].name, ".data1"},   data1_o, vecs[i].e_data1);
      check({vecs[i].name, ".data2"},   data2_o, vecs[i].e_data2);
      check({vecs[i].name, ".store"},   store_data_o, vecs[i].e_store);
      check({vecs[i].name, ".aluctrl"}, 32'(ALUCtrl_o), 32'(vecs[i].e_alu));
    end
    no_fwd();

    // Stall for two edges while ID presents a different instruction.
    valid_i = 1; RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 0;
    ALUOp_i = 2'b10; funct_i = 6'h22; ALUSrc_i = 0;
    RSdata_i = 32'h1234; RTdata_i = 32'h0042; RSaddr_i = 5'd11; RTaddr_i = 5'd12; RDaddr_i = 5'd13;
    step();
    check_all("load");
    stall_i = 1;
    RSdata_i = 32'hDEAD; RTdata_i = 32'hBEEF; ALUOp_i = 2'b11; RDaddr_i = 5'd30; MemWrite_i = 1;
    step(); step();
    check_all("stall2");
    check("stall2.hold_data1", data1_o, 32'h1234);
    check("stall2.hold_rd",    32'(RDaddr_o), 32'd13);

    // Flush wins over stall.
    step();
    flush_i = 1;
    step();
    check("flush.valid",    32'(valid_o), 32'h0);
    check("flush.memwrite", 32'(MemWrite_o), 32'h0);
    check("flush.rdaddr",   32'(RDaddr_o), 32'h0);
    check_all("flush");
    stall_i = 0; flush_i = 0;

    // Invalid slot with write controls set: writes suppressed, MemtoReg passes.
    valid_i = 0; RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 1;
    step();
    check("inv.regwrite", 32'(RegWrite_o), 32'h0);
    check("inv.memwrite", 32'(MemWrite_o), 32'h0);
    check("inv.memtoreg", 32'(MemtoReg_o), 32'h1);
    check_all("inv");

    // Asynchronous reset between edges, while stalled and flushing.
    valid_i = 1; ALUOp_i = 2'b01;
    step();
    check("pre_rst.valid", 32'(valid_o), 32'h1);
    stall_i = 1; flush_i = 1;
    #3 rst_i = 1;
    #1;
    held = zero_instr();
    check("arst.valid",   32'(valid_o), 32'h0);
    check("arst.aluctrl", 32'(ALUCtrl_o), 32'h2);
    check("arst.ctrl",    32'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o}), 32'h0);
    step();
    #2 rst_i = 0;
    stall_i = 0; flush_i = 0;

    // Random traffic with small address space so forwarding hits are frequent.
    for (int n = 0; n < 300; n++) begin
      valid_i = 1'($urandom); RegWrite_i = 1'($urandom); MemtoReg_i = 1'($urandom);
      MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom); ALUSrc_i = 1'($urandom);
      ALUOp_i = 2'($urandom);
      funct_i = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'(32 + 2 * $urandom_range(0, 5));
      RSdata_i = $urandom; RTdata_i = $urandom; imm_i = $urandom;
      RSaddr_i = 5'($urandom_range(0, 3)); RTaddr_i = 5'($urandom_range(0, 3));
      RDaddr_i = 5'($urandom);
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      step();
      EXMEM_RegWrite_i = 1'($urandom); EXMEM_RDaddr_i = 5'($urandom_range(0, 3)); EXMEM_data_i = $urandom;
      MEMWB_RegWrite_i = 1'($urandom); MEMWB_RDaddr_i = 5'($urandom_range(0, 3)); MEMWB_data_i = $urandom;
      #1;
      check_all($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
